// File: rtl/parity_chk_skid_if.sv
// Valid/ready channel plus error-reporting sideband for parity_chk_skid.
interface parity_chk_skid_if #(
   parameter int unsigned DW    = 32,
   parameter int unsigned PW    = 1,
   parameter int unsigned CNT_W = 8
) ();
   logic             S_VALID;
   logic [DW-1:0]    S_DATA;
   logic [PW-1:0]    S_PARITY;
   logic             S_READY;
   logic             M_VALID;
   logic [DW-1:0]    M_DATA;
   logic [PW-1:0]    M_PARITY;
   logic             M_READY;
   logic             ENERR;
   logic [PW-1:0]    FIERR;
   logic             ERR;
   logic             ERR_B;
   logic             ERR_STICKY;
   logic [CNT_W-1:0] ERR_CNT;
   logic             ERR_CLR;

   modport master (
      output S_VALID, S_DATA, S_PARITY, M_READY, ENERR, FIERR, ERR_CLR,
      input  S_READY, M_VALID, M_DATA, M_PARITY, ERR, ERR_B, ERR_STICKY, ERR_CNT
   );

   modport slave (
      input  S_VALID, S_DATA, S_PARITY, M_READY, ENERR, FIERR, ERR_CLR,
      output S_READY, M_VALID, M_DATA, M_PARITY, ERR, ERR_B, ERR_STICKY, ERR_CNT
   );
endinterface

// File: rtl/parity_chk_skid.sv
// Receive-side parity checker with a 2-entry skid buffer; forwards data with
// regenerated parity and reports mismatches as pulse, sticky flag and counter.
module parity_chk_skid #(
   parameter int unsigned DW    = 32,
   parameter int unsigned PW    = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic           ACLK,
   input  logic           RESETN_ACLK,
   parity_chk_skid_if.slave bus
);

   localparam int unsigned         SW      = DW / PW;
   localparam logic [CNT_W-1:0]    CNT_MAX = '1;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   // Even parity per slice.
   function automatic logic [PW-1:0] slice_parity(input logic [DW-1:0] d);
      logic [PW-1:0] p;
      p = '0;
      for (int k = 0; k < int'(PW); k++) p[k] = ^d[k*SW +: SW];
      return p;
   endfunction

   state_t           state_q, state_d;
   logic [DW-1:0]    m_data_q, m_data_d;
   logic [PW-1:0]    m_par_q, m_par_d;
   logic [DW-1:0]    skid_q, skid_d;
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   logic             err_q, err_d;
   logic             err_b_q, err_b_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, send, mismatch;
   logic [PW-1:0]    calc;

   always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
      if (!RESETN_ACLK) begin
         state_q   <= EMPTY;
         m_data_q  <= '0;
         m_par_q   <= '0;
         skid_q    <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
         err_b_q   <= 1'b1;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         m_data_q  <= m_data_d;
         m_par_q   <= m_par_d;
         skid_q    <= skid_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         err_q     <= err_d;
         err_b_q   <= err_b_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
      end
   end

   // Buffer control: head lives in the output register, second beat in skid.
   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_par_d  = m_par_q;
      skid_d   = skid_q;
      accept   = bus.S_VALID & s_ready_q;
      send     = m_valid_q & bus.M_READY;
      calc     = slice_parity(bus.S_DATA);

      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d  = ONE;
               m_data_d = bus.S_DATA;
               m_par_d  = calc;
            end
         end
         ONE: begin
            if (accept && send) begin
               m_data_d = bus.S_DATA;
               m_par_d  = calc;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = bus.S_DATA;
            end else if (send) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (send) begin
               state_d  = ONE;
               m_data_d = skid_q;
               m_par_d  = slice_parity(skid_q);
            end
         end
         default: state_d = EMPTY;
      endcase

      s_ready_d = (state_d != FULL);
      m_valid_d = (state_d != EMPTY);

      // Error bookkeeping; a clear coinciding with a new error keeps that error.
      mismatch = accept & bus.ENERR & (calc != (bus.S_PARITY ^ bus.FIERR));
      err_d    = mismatch;
      err_b_d  = ~mismatch;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (bus.ERR_CLR) begin
         sticky_d = mismatch;
         cnt_d    = CNT_W'(mismatch);
      end else if (mismatch) begin
         sticky_d = 1'b1;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign bus.S_READY    = s_ready_q;
   assign bus.M_VALID    = m_valid_q;
   assign bus.M_DATA     = m_data_q;
   assign bus.M_PARITY   = m_par_q;
   assign bus.ERR        = err_q;
   assign bus.ERR_B      = err_b_q;
   assign bus.ERR_STICKY = sticky_q;
   assign bus.ERR_CNT    = cnt_q;

endmodule

// File: tb/tb_parity_chk_skid.sv
// Scoreboard bench for parity_chk_skid: directed scenarios followed by random traffic.
module tb_parity_chk_skid;
   localparam int unsigned DW    = 32;
   localparam int unsigned PW    = 1;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned SW    = DW / PW;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;

   parity_chk_skid_if #(.DW(DW), .PW(PW), .CNT_W(CNT_W)) bus ();

   parity_chk_skid #(.DW(DW), .PW(PW), .CNT_W(CNT_W)) dut (
      .ACLK        (clk),
      .RESETN_ACLK (rst_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state.
   logic [DW-1:0] q[$];
   bit  warm     = 0;
   bit  err_e    = 0;
   bit  sticky_e = 0;
   int  cnt_e    = 0;

   function automatic logic [PW-1:0] ref_par(input logic [DW-1:0] d);
      logic [PW-1:0] p;
      logic [DW-1:0] s;
      logic [DW-1:0] mask;
      p    = '0;
      mask = DW'((64'd1 << SW) - 64'd1);
      for (int k = 0; k < int'(PW); k++) begin
         s    = (d >> (k * SW)) & mask;
         p[k] = ($countones(s) % 2) == 1;
      end
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT state against the model, then advances the model.
   always @(negedge clk) begin
      bit acc, snd, mis, ready_e;
      if (!rst_n) begin
         q.delete();
         warm = 0; err_e = 0; sticky_e = 0; cnt_e = 0;
         check("rst_s_ready", 64'(bus.S_READY), 64'd0);
         check("rst_m_valid", 64'(bus.M_VALID), 64'd0);
         check("rst_m_data", 64'(bus.M_DATA), 64'd0);
         check("rst_m_parity", 64'(bus.M_PARITY), 64'd0);
         check("rst_err", 64'(bus.ERR), 64'd0);
         check("rst_err_b", 64'(bus.ERR_B), 64'd1);
         check("rst_sticky", 64'(bus.ERR_STICKY), 64'd0);
         check("rst_cnt", 64'(bus.ERR_CNT), 64'd0);
      end else begin
         ready_e = warm && (q.size() < 2);
         check("s_ready", 64'(bus.S_READY), 64'(ready_e));
         check("m_valid", 64'(bus.M_VALID), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check("m_data", 64'(bus.M_DATA), 64'(q[0]));
            check("m_parity", 64'(bus.M_PARITY), 64'(ref_par(q[0])));
         end
         check("err", 64'(bus.ERR), 64'(err_e));
         check("err_b", 64'(bus.ERR_B), 64'(!err_e));
         check("err_sticky", 64'(bus.ERR_STICKY), 64'(sticky_e));
         check("err_cnt", 64'(bus.ERR_CNT), 64'(cnt_e));

         acc = bus.S_VALID && ready_e;
         snd = bus.M_READY && (q.size() != 0);
         mis = acc && bus.ENERR && (ref_par(bus.S_DATA) != (bus.S_PARITY ^ bus.FIERR));
         err_e = mis;
         if (bus.ERR_CLR) begin
            sticky_e = mis;
            cnt_e    = mis ? 1 : 0;
         end else if (mis) begin
            sticky_e = 1;
            cnt_e    = (cnt_e < CMAX) ? cnt_e + 1 : CMAX;
         end
         if (snd) void'(q.pop_front());
         if (acc) q.push_back(bus.S_DATA);
         warm = 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic [PW-1:0] fi);
      bus.S_VALID  = 1'b1;
      bus.S_DATA   = d;
      bus.S_PARITY = p;
      bus.FIERR    = fi;
   endtask

   // Holds the current beat until the handshake completes, bounded.
   task automatic wait_accept();
      int   n;
      logic hs;
      n = 0;
      do begin
         @(negedge clk);
         hs = bus.S_READY;
         step();
         n++;
      end while (!hs && n < 50);
      n_chk++;
      if (!hs) begin
         n_fail++;
         $display("FAIL accept_timeout: got no handshake, expected one within 50 cycles at %0t", $time);
      end
      bus.S_VALID = 1'b0;
      bus.FIERR   = '0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic [PW-1:0] fi);
      drive_beat(d, p, fi);
      wait_accept();
   endtask

   initial begin
      logic [DW-1:0] d;
      rst_n       = 1'b0;
      bus.M_READY = 1'b1;
      bus.ENERR   = 1'b1;
      bus.ERR_CLR = 1'b0;
      drive_beat(32'hDEAD_0000, 1'b1, 1'b0);
      repeat (3) step();
      rst_n = 1'b1;
      wait_accept();

      // Streaming with correct parity.
      for (int i = 0; i < 5; i++) begin
         d = 32'hCAFE_0000 + DW'(i << 8);
         send_beat(d, ref_par(d), 1'b0);
      end

      // Fault injection on a correctly-parity'd beat.
      send_beat(32'hBEEF_0100, 1'b0, 1'b1);
      repeat (3) step();

      // Detection disabled: bad parity plus injection is silently forwarded.
      bus.ENERR = 1'b0;
      d = 32'h1234_5678;
      send_beat(d, ~ref_par(d), 1'b1);
      repeat (2) step();
      bus.ENERR = 1'b1;

      // Backpressure fills both entries, third beat waits upstream.
      bus.M_READY = 1'b0;
      send_beat(32'hAAAA_0001, ref_par(32'hAAAA_0001), 1'b0);
      send_beat(32'hBBBB_0002, ref_par(32'hBBBB_0002), 1'b0);
      drive_beat(32'hCCCC_0003, ref_par(32'hCCCC_0003), 1'b0);
      repeat (3) step();
      bus.M_READY = 1'b1;
      wait_accept();
      repeat (4) step();

      // Counter saturation, then clear coinciding with a new error.
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         send_beat(d, ref_par(d), 1'b1);
      end
      step();
      bus.ERR_CLR = 1'b1;
      d = $urandom;
      send_beat(d, ref_par(d), 1'b1);
      bus.ERR_CLR = 1'b0;
      repeat (2) step();

      // Reset while the buffer is full.
      bus.M_READY = 1'b0;
      send_beat(32'h0101_0101, ref_par(32'h0101_0101), 1'b0);
      send_beat(32'h0202_0202, ref_par(32'h0202_0202), 1'b0);
      step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      bus.M_READY = 1'b1;
      repeat (2) step();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         d            = $urandom;
         bus.S_VALID  = ($urandom % 4) != 0;
         bus.S_DATA   = d;
         bus.S_PARITY = ref_par(d) ^ PW'(($urandom % 5) == 0);
         bus.FIERR    = PW'(($urandom % 8) == 0);
         bus.ENERR    = ($urandom % 4) != 0;
         bus.M_READY  = ($urandom % 3) != 0;
         bus.ERR_CLR  = ($urandom % 32) == 0;
         rst_n        = ($urandom % 500) != 0;
         step();
      end
      rst_n       = 1'b1;
      bus.S_VALID = 1'b0;
      bus.ERR_CLR = 1'b0;
      bus.FIERR   = '0;
      bus.M_READY = 1'b1;
      repeat (5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/parity_chk_skid.md
Name: parity_chk_skid

Overview:
Receive-side parity checker with a 2-entry skid buffer, placed on a valid/ready channel directly upstream of the core's write-address path.
- Accepts data and its parity, checks the parity on every accepted beat, and forwards the data unchanged with freshly generated parity.
- Reports errors as a one-cycle pulse plus its complement, a sticky flag and a saturating counter.
- Supports error-enable gating and fault injection for safety testing.

Parameters:
DW, 32, data width in bits; must be divisible by PW.
PW, 1, number of parity bits; bit k covers data slice [k*DW/PW +: DW/PW].
CNT_W, 8, width of the error counter.

Ports:
ACLK  in  1  clock; all logic on its rising edge.
RESETN_ACLK  in  1  asynchronous active-low reset.
S_VALID  in  1  upstream beat valid.
S_DATA  in  DW  upstream data.
S_PARITY  in  PW  upstream even parity, per slice.
S_READY  out  1  buffer can accept a beat.
M_VALID  out  1  downstream beat valid.
M_DATA  out  DW  downstream data.
M_PARITY  out  PW  even parity regenerated from M_DATA.
M_READY  in  1  downstream accepts.
ENERR  in  1  error detection enable.
FIERR  in  PW  fault-injection mask; XORed into the received parity.
ERR  out  1  one-cycle error pulse.
ERR_B  out  1  always the complement of ERR.
ERR_STICKY  out  1  latched error flag.
ERR_CNT  out  CNT_W  saturating count of detected errors.
ERR_CLR  in  1  synchronous clear of ERR_STICKY and ERR_CNT.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Buffer emptied; stored beats are discarded.
  - S_READY=0, M_VALID=0, M_DATA=0, M_PARITY=0.
  - ERR=0, ERR_B=1, ERR_STICKY=0, ERR_CNT=0.
  - S_READY rises at the first ACLK edge after RESETN_ACLK deasserts.
- Handshakes:
  - Accept = S_VALID&S_READY; send = M_VALID&M_READY.
  - S_VALID and S_DATA are ignored while S_READY=0.
- Buffer FSM, states EMPTY/ONE/FULL:
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL; send only -> EMPTY; accept and send together -> ONE.
  - FULL: send -> ONE. No accept is possible because S_READY=0.
- Buffer outputs and ordering:
  - S_READY is registered: 1 in EMPTY/ONE, 0 in FULL.
  - M_VALID=1 in ONE/FULL.
  - Strict FIFO order. M_DATA/M_PARITY hold stable while M_VALID=1 and M_READY=0.
- Latency and throughput:
  - A beat accepted into EMPTY appears on M_* at the next edge (1 cycle).
  - Sustained 1 beat/cycle when M_READY=1.
- Parity arithmetic:
  - calc[k] = XOR of S_DATA slice k (even parity).
  - eff[k] = S_PARITY[k] ^ FIERR[k], sampled at accept.
  - mismatch = accept & ENERR & (calc != eff); any bit mismatching counts as one error.
- Error outputs:
  - ERR is registered: it pulses for exactly 1 cycle at the edge after a mismatching accept.
  - ERR_B = ~ERR at all times, including during reset.
  - ENERR=0: ERR never asserts, counters are unaffected, data still flows.
  - FIERR has no effect without an accept.
- Data forwarding:
  - Data is forwarded regardless of the error outcome.
  - M_PARITY is always recomputed from M_DATA, so it is never corrupted by FIERR.
- ERR_STICKY:
  - Set on the ERR pulse; cleared by ERR_CLR.
  - If set and clear coincide (mismatch registered on the same edge as ERR_CLR), the result is 1.
- ERR_CNT:
  - +1 per ERR pulse; saturates at 2^CNT_W-1 with no wrap.
  - ERR_CLR -> 0. ERR_CLR together with a new error -> 1.

Test Plan:
- Reset release with S_VALID=1, S_DATA=0xDEAD0000, S_PARITY=1 -> S_READY=0 during reset; accepted at the first edge with S_READY=1; M_VALID=1 with M_DATA=0xDEAD0000, M_PARITY=1 one cycle later; ERR=0, ERR_B=1.
- ENERR=1, five beats 0xCAFE0000+(i<<8) with correct parity, M_READY=1 -> 1 beat/cycle out in order; ERR stays 0; ERR_CNT=0.
- ENERR=1, FIERR=1 for one beat 0xBEEF0100 with parity 0 -> ERR=1 for exactly one cycle at the edge after accept, ERR_B=0 that cycle; ERR_STICKY=1; ERR_CNT=1; M_PARITY=0 (uncorrupted).
- ENERR=0, FIERR=1, wrong parity -> no ERR, ERR_CNT unchanged, data forwarded.
- M_READY=0, three back-to-back beats A, B, C -> A and B buffered, S_READY=0 (FULL), C held upstream; M_READY=1 -> A, B, C delivered in order with no loss.
- CNT_W=2, 4 errors -> ERR_CNT saturates at 3; ERR_CLR coinciding with a 5th error -> ERR_CNT=1, ERR_STICKY=1; RESETN_ACLK asserted mid-FULL -> buffer empty, all outputs at reset values.
